window_gen_3x3: RTL and testbench

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

---
 rtl/window_gen_3x3.sv | 128 ++++++++++++
 tb/tb_window_gen_3x3.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator for a raster RGB stream.
// Two line buffers feed a shift window; windows are emitted only for interior centres.
module window_gen_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    output logic [7:0]  a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r, i_r,
    output logic [7:0]  a_g, b_g, c_g, d_g, e_g, f_g, g_g, h_g, i_g,
    output logic [7:0]  a_b, b_b, c_b, d_b, e_b, f_b, g_b, h_b, i_b,
    output logic        win_valid,
    output logic [10:0] win_x,
    output logic [10:0] win_y,
    output logic        frame_done
);
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
    localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);

    state_t state, state_d;
    logic [10:0] col, row, col_e, row_e;
    logic        accept, at_eol, at_eof, emit;
    logic [23:0] pix, lb1_rd, lb2_rd;
    logic [AW-1:0] waddr;
    logic [23:0] lb1 [IMG_W];
    logic [23:0] lb2 [IMG_W];
    logic [2:0][23:0] new_col;
    logic [2:0][1:0][23:0] sw;      // two older window columns; the newest comes from new_col
    logic [2:0][2:0][23:0] win_q;

    assign pix    = {in_r, in_g, in_b};
    assign accept = in_valid && (in_sof || state != IDLE);
    // A start-of-frame pixel is always (0,0), whatever the counters say.
    assign col_e  = in_sof ? 11'd0 : col;
    assign row_e  = in_sof ? 11'd0 : row;
    assign waddr  = col_e[AW-1:0];
    assign lb1_rd = lb1[waddr];
    assign lb2_rd = lb2[waddr];
    assign at_eol = (col_e == X_LAST);
    assign at_eof = at_eol && (row_e == Y_LAST);
    // col >= 2 keeps columns 0 and IMG_W-1 out of the centre, so no window spans a line wrap.
    assign emit   = accept && (state == RUN) && !in_sof && (col_e >= 11'd2);

    assign new_col[0] = lb2_rd;
    assign new_col[1] = lb1_rd;
    assign new_col[2] = pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (in_valid && in_sof) state_d = FILL;
            FILL: if (accept && col_e == 11'd1 && row_e == 11'd2) state_d = RUN;
            RUN: begin
                if (accept && in_sof)       state_d = FILL;
                else if (accept && at_eof)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            col <= at_eol ? 11'd0 : col_e + 11'd1;
            row <= at_eof ? 11'd0 : (at_eol ? row_e + 11'd1 : row_e);
        end
    end

    // Storage is left unreset: FILL rewrites every entry before it can reach a window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[waddr] <= pix;
            lb2[waddr] <= lb1_rd;
            for (int r = 0; r < 3; r++) begin
                sw[r][0] <= sw[r][1];
                sw[r][1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= '0;
            win_x      <= '0;
            win_y      <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= emit;
            frame_done <= emit && at_eof;
            if (emit) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= sw[r][0];
                    win_q[r][1] <= sw[r][1];
                    win_q[r][2] <= new_col[r];
                end
                win_x <= col_e - 11'd1;
                win_y <= row_e - 11'd1;
            end
        end
    end

    assign a_r = win_q[0][0][23:16]; assign a_g = win_q[0][0][15:8]; assign a_b = win_q[0][0][7:0];
    assign b_r = win_q[0][1][23:16]; assign b_g = win_q[0][1][15:8]; assign b_b = win_q[0][1][7:0];
    assign c_r = win_q[0][2][23:16]; assign c_g = win_q[0][2][15:8]; assign c_b = win_q[0][2][7:0];
    assign d_r = win_q[1][0][23:16]; assign d_g = win_q[1][0][15:8]; assign d_b = win_q[1][0][7:0];
    assign e_r = win_q[1][1][23:16]; assign e_g = win_q[1][1][15:8]; assign e_b = win_q[1][1][7:0];
    assign f_r = win_q[1][2][23:16]; assign f_g = win_q[1][2][15:8]; assign f_b = win_q[1][2][7:0];
    assign g_r = win_q[2][0][23:16]; assign g_g = win_q[2][0][15:8]; assign g_b = win_q[2][0][7:0];
    assign h_r = win_q[2][1][23:16]; assign h_g = win_q[2][1][15:8]; assign h_b = win_q[2][1][7:0];
    assign i_r = win_q[2][2][23:16]; assign i_g = win_q[2][2][15:8]; assign i_b = win_q[2][2][7:0];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: a 5x4 instance and a 3x3 instance share one input stream.
module tb_window_gen_3x3;
    typedef logic [26:0][7:0] win_t;   // [ch*9 + pos], ch 0=r 1=g 2=b, pos 0..8 = a..i

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_sof;
    logic [7:0] in_r, in_g, in_b;
    win_t w1, w2;
    logic v1, fd1, v2, fd2;
    logic [10:0] x1, y1, x2, y2;
    int n_chk = 0;
    int n_fail = 0;

    // first window of a 10*row+col frame, hand-computed: a..i = 0,1,2,10,11,12,20,21,22
    logic [8:0][7:0] first_win;
    assign first_win = {8'd22, 8'd21, 8'd20, 8'd12, 8'd11, 8'd10, 8'd2, 8'd1, 8'd0};

    always #5 clk = ~clk;

    window_gen_3x3 #(.IMG_W(5), .IMG_H(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .a_r(w1[0]),  .b_r(w1[1]),  .c_r(w1[2]),  .d_r(w1[3]),  .e_r(w1[4]),
        .f_r(w1[5]),  .g_r(w1[6]),  .h_r(w1[7]),  .i_r(w1[8]),
        .a_g(w1[9]),  .b_g(w1[10]), .c_g(w1[11]), .d_g(w1[12]), .e_g(w1[13]),
        .f_g(w1[14]), .g_g(w1[15]), .h_g(w1[16]), .i_g(w1[17]),
        .a_b(w1[18]), .b_b(w1[19]), .c_b(w1[20]), .d_b(w1[21]), .e_b(w1[22]),
        .f_b(w1[23]), .g_b(w1[24]), .h_b(w1[25]), .i_b(w1[26]),
        .win_valid(v1), .win_x(x1), .win_y(y1), .frame_done(fd1)
    );

    window_gen_3x3 #(.IMG_W(3), .IMG_H(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .a_r(w2[0]),  .b_r(w2[1]),  .c_r(w2[2]),  .d_r(w2[3]),  .e_r(w2[4]),
        .f_r(w2[5]),  .g_r(w2[6]),  .h_r(w2[7]),  .i_r(w2[8]),
        .a_g(w2[9]),  .b_g(w2[10]), .c_g(w2[11]), .d_g(w2[12]), .e_g(w2[13]),
        .f_g(w2[14]), .g_g(w2[15]), .h_g(w2[16]), .i_g(w2[17]),
        .a_b(w2[18]), .b_b(w2[19]), .c_b(w2[20]), .d_b(w2[21]), .e_b(w2[22]),
        .f_b(w2[23]), .g_b(w2[24]), .h_b(w2[25]), .i_b(w2[26]),
        .win_valid(v2), .win_x(x2), .win_y(y2), .frame_done(fd2)
    );

    // mode 0: every channel = 10*row+col; mode 1: R=col, G=row, B=255-col
    function automatic logic [7:0] pix(input int mode, input int ch, input int x, input int y);
        if (mode == 0) return 8'(10 * y + x);
        case (ch)
            0:       return 8'(x);
            1:       return 8'(y);
            default: return 8'(255 - x);
        endcase
    endfunction

    function automatic win_t exp_win(input int mode, input int cx, input int cy);
        win_t e;
        for (int ch = 0; ch < 3; ch++)
            for (int k = 0; k < 9; k++)
                e[ch*9 + k] = pix(mode, ch, cx + (k % 3) - 1, cy + (k / 3) - 1);
        return e;
    endfunction

    task automatic push(input bit sof, input int mode, input int x, input int y);
        in_valid = 1'b1;
        in_sof   = sof;
        in_r = pix(mode, 0, x, y);
        in_g = pix(mode, 1, x, y);
        in_b = pix(mode, 2, x, y);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (v1 !== 1'b0 || fd1 !== 1'b0) begin n_fail++; $display("FAIL reset_flags: valid=%b done=%b, want 0 0", v1, fd1); end
        n_chk++; if (x1 !== 11'd0 || y1 !== 11'd0) begin n_fail++; $display("FAIL reset_xy: x=%0d y=%0d, want 0 0", x1, y1); end
        n_chk++; if (w1 !== '0) begin n_fail++; $display("FAIL reset_window: got %h, want 0", w1); end
        n_chk++; if (v2 !== 1'b0 || w2 !== '0) begin n_fail++; $display("FAIL reset_dut3: valid=%b win=%h, want 0", v2, w2); end
        rst_n = 1'b1;
        idle_cycle();
    endtask

    // full 5x4 frame; with gaps an idle cycle follows every pixel and outputs must hold
    task automatic test_frame(input string name, input int mode, input bit gaps);
        int nwin = 0, nfd = 0;
        bit seen = 1'b0;
        win_t held_w;
        int hx = 0, hy = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 5; x++) begin
                bit ev;
                push(x == 0 && y == 0, mode, x, y);
                ev = (x >= 2 && y >= 2);
                n_chk++; if (v1 !== ev) begin n_fail++; $display("FAIL %s_valid (%0d,%0d): got %b want %b", name, x, y, v1, ev); end
                if (fd1 === 1'b1) nfd++;
                if (ev) begin
                    nwin++;
                    held_w = exp_win(mode, x - 1, y - 1); hx = x - 1; hy = y - 1; seen = 1'b1;
                    n_chk++; if (x1 !== 11'(hx) || y1 !== 11'(hy)) begin n_fail++; $display("FAIL %s_xy: got (%0d,%0d) want (%0d,%0d)", name, x1, y1, hx, hy); end
                    n_chk++; if (w1 !== held_w) begin n_fail++; $display("FAIL %s_window (%0d,%0d): got %h want %h", name, hx, hy, w1, held_w); end
                    n_chk++; if (fd1 !== (x == 4 && y == 3)) begin n_fail++; $display("FAIL %s_done at (%0d,%0d): got %b", name, hx, hy, fd1); end
                    if (mode == 0 && x == 2 && y == 2) begin
                        n_chk++; if (w1[8:0] !== first_win) begin n_fail++; $display("FAIL %s_first_window: got %h want %h", name, w1[8:0], first_win); end
                    end
                end
                if (gaps) begin
                    idle_cycle();
                    n_chk++; if (v1 !== 1'b0 || fd1 !== 1'b0) begin n_fail++; $display("FAIL %s_gap_pulse: valid=%b done=%b", name, v1, fd1); end
                    if (seen) begin
                        n_chk++; if (w1 !== held_w || x1 !== 11'(hx) || y1 !== 11'(hy)) begin n_fail++; $display("FAIL %s_hold: got (%0d,%0d) %h want (%0d,%0d) %h", name, x1, y1, w1, hx, hy, held_w); end
                    end
                end
            end
        end
        idle_cycle();
        n_chk++; if (v1 !== 1'b0 || fd1 !== 1'b0) begin n_fail++; $display("FAIL %s_after: valid=%b done=%b", name, v1, fd1); end
        n_chk++; if (nwin != 6 || nfd != 1) begin n_fail++; $display("FAIL %s_count: windows=%0d done=%0d want 6 1", name, nwin, nfd); end
    endtask

    // restart on pixel (2,2) of frame 1: that pixel becomes (0,0) of frame 2
    task automatic test_restart();
        int nwin = 0, nfd = 0;
        for (int p = 0; p < 12; p++) begin
            push(p == 0, 0, p % 5, p / 5);
            n_chk++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL restart_frame1 pixel %0d: got valid %b want 0", p, v1); end
        end
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 5; x++) begin
                push(x == 0 && y == 0, 1, x, y);
                if (fd1 === 1'b1) nfd++;
                n_chk++; if (v1 !== (x >= 2 && y >= 2)) begin n_fail++; $display("FAIL restart_valid (%0d,%0d): got %b", x, y, v1); end
                if (v1 === 1'b1) begin
                    nwin++;
                    n_chk++; if (w1 !== exp_win(1, x - 1, y - 1)) begin n_fail++; $display("FAIL restart_window (%0d,%0d): got %h want %h", x - 1, y - 1, w1, exp_win(1, x - 1, y - 1)); end
                end
            end
        end
        idle_cycle();
        n_chk++; if (nwin != 6 || nfd != 1) begin n_fail++; $display("FAIL restart_count: windows=%0d done=%0d want 6 1", nwin, nfd); end
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 14; p++) push(p == 0, 0, p % 5, p / 5);
        n_chk++; if (v1 !== 1'b1 || x1 !== 11'd2 || y1 !== 11'd1) begin n_fail++; $display("FAIL midreset_pre: valid=%b (%0d,%0d) want 1 (2,1)", v1, x1, y1); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (v1 !== 1'b0 || fd1 !== 1'b0 || x1 !== 11'd0 || y1 !== 11'd0 || w1 !== '0) begin n_fail++; $display("FAIL midreset_clear: valid=%b (%0d,%0d) win=%h", v1, x1, y1, w1); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int p = 14; p < 20; p++) begin
            push(1'b0, 0, p % 5, p / 5);
            n_chk++; if (v1 !== 1'b0 || w1 !== '0 || x1 !== 11'd0) begin n_fail++; $display("FAIL midreset_nosof pixel %0d: valid=%b x=%0d win=%h", p, v1, x1, w1); end
        end
        idle_cycle();
        test_frame("postreset", 0, 1'b0);
    endtask

    task automatic test_3x3();
        int nwin = 0;
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 3; x++) begin
                push(x == 0 && y == 0, 0, x, y);
                n_chk++; if (v2 !== (x == 2 && y == 2)) begin n_fail++; $display("FAIL small_valid (%0d,%0d): got %b", x, y, v2); end
                n_chk++; if (fd2 !== (x == 2 && y == 2)) begin n_fail++; $display("FAIL small_done (%0d,%0d): got %b", x, y, fd2); end
                if (v2 === 1'b1) begin
                    nwin++;
                    n_chk++; if (x2 !== 11'd1 || y2 !== 11'd1) begin n_fail++; $display("FAIL small_xy: got (%0d,%0d) want (1,1)", x2, y2); end
                    n_chk++; if (w2[8:0] !== first_win || w2[17:9] !== first_win || w2[26:18] !== first_win) begin n_fail++; $display("FAIL small_window: got %h want %h on each channel", w2, first_win); end
                end
            end
        end
        idle_cycle();
        n_chk++; if (nwin != 1 || v2 !== 1'b0 || fd2 !== 1'b0) begin n_fail++; $display("FAIL small_count: windows=%0d valid=%b done=%b", nwin, v2, fd2); end
    endtask

    initial begin
        test_reset();
        test_frame("basic", 0, 1'b0);
        test_frame("gaps", 0, 1'b1);
        test_frame("channels", 1, 1'b0);
        test_restart();
        test_reset_mid();
        test_3x3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
